// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the single-master bus fabric:
//                FSM state encoding, wait-state field width and the
//                default open-bus read value.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Width of one per-slave wait-state field in the packed WAIT parameter
  localparam int WAIT_W = 4;

  // Value returned on reads that reach no slave
  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

  // Transaction FSM
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : bus_addr_decoder
//  Description : Combinational base/mask address decoder. Produces a
//                priority-resolved one-hot hit vector (lowest slave index
//                wins on overlapping maps) and an any-hit flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_addr_decoder
  import bus_pkg::*;
#(
  parameter int                         ADDR_W = 16,
  parameter int                         NSLAVE = 4,
  parameter logic [NSLAVE*ADDR_W-1:0]   BASE   = '0,
  parameter logic [NSLAVE*ADDR_W-1:0]   MASK   = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [NSLAVE-1:0] hit_o,
  output logic              any_hit_o
);

  logic w_found;

  // Scan slaves from index 0 upward; the first match claims the access
  always_comb begin
    hit_o   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (!w_found &&
          ((addr_i & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W])) begin
        hit_o[i] = 1'b1;
        w_found  = 1'b1;
      end
    end
    any_hit_o = w_found;
  end

endmodule : bus_addr_decoder
`default_nettype wire

// File: rtl/bus_fabric.sv
`default_nettype none
// ============================================================================
//  Module      : bus_fabric
//  Description : Single-master bus fabric. Bridges the core's active-low
//                read/write strobe bus to NSLAVE memory-mapped slaves with
//                address decoding, per-slave wait states, a one-cycle
//                m_ready completion pulse, registered read data, open-bus
//                reads for unmapped addresses and a sticky error flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_fabric
  import bus_pkg::*;
#(
  parameter int                         ADDR_W   = 16,
  parameter int                         DATA_W   = 8,
  parameter int                         NSLAVE   = 4,
  parameter logic [NSLAVE*ADDR_W-1:0]   BASE     = '0,
  parameter logic [NSLAVE*ADDR_W-1:0]   MASK     = '0,
  parameter logic [NSLAVE*WAIT_W-1:0]   WAIT     = '0,
  parameter logic [DATA_W-1:0]          OPEN_BUS = OPEN_BUS_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  // master side
  input  logic [ADDR_W-1:0]        m_addr,
  input  logic [DATA_W-1:0]        m_wdata,
  input  logic                     m_nread,
  input  logic                     m_nwrite,
  output logic [DATA_W-1:0]        m_rdata,
  output logic                     m_ready,
  output logic                     err,
  // slave side
  output logic [ADDR_W-1:0]        s_addr,
  output logic [DATA_W-1:0]        s_wdata,
  output logic                     s_nread,
  output logic                     s_nwrite,
  output logic [NSLAVE-1:0]        s_nsel,
  input  logic [NSLAVE*DATA_W-1:0] s_rdata
);

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                rd_q;
  logic [NSLAVE-1:0]   sel_q;
  logic [WAIT_W-1:0]   cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                ready_q;
  logic                err_q;
  logic [NSLAVE-1:0]   nsel_q;
  logic                nrd_q;
  logic                nwr_q;

  logic [NSLAVE-1:0]   w_hit;
  logic                w_any_hit;
  logic [WAIT_W-1:0]   w_wait;
  logic [DATA_W-1:0]   w_sel_rdata;
  logic                w_req;
  logic                w_both;
  logic                w_bus_idle;

  assign w_req      = ~m_nread | ~m_nwrite;
  assign w_both     = ~m_nread & ~m_nwrite;
  assign w_bus_idle =  m_nread &  m_nwrite;

  bus_addr_decoder #(
    .ADDR_W (ADDR_W),
    .NSLAVE (NSLAVE),
    .BASE   (BASE),
    .MASK   (MASK)
  ) u_dec (
    .addr_i    (m_addr),
    .hit_o     (w_hit),
    .any_hit_o (w_any_hit)
  );

  // Wait-state count of the decoded slave (hit vector is one-hot, so AND-OR)
  always_comb begin
    w_wait = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (w_hit[i]) w_wait = w_wait | WAIT[i*WAIT_W +: WAIT_W];
    end
  end

  // Read-data mux driven by the slave latched at request time
  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < NSLAVE; i++) begin
      if (sel_q[i]) w_sel_rdata = w_sel_rdata | s_rdata[i*DATA_W +: DATA_W];
    end
  end

  // Transaction FSM with registered slave strobes, ready pulse and read data
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      sel_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= OPEN_BUS;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      nsel_q  <= '1;
      nrd_q   <= 1'b1;
      nwr_q   <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_req) begin
            addr_q  <= m_addr;
            wdata_q <= m_wdata;
            rd_q    <= ~m_nread;
            if (w_both || !w_any_hit) begin
              // Unmapped or conflicting strobes: finish immediately, touch no slave
              sel_q   <= '0;
              cnt_q   <= '0;
              err_q   <= 1'b1;
              ready_q <= 1'b1;
              if (!m_nread) rdata_q <= OPEN_BUS;
              state_q <= ST_DONE;
            end else begin
              sel_q   <= w_hit;
              cnt_q   <= w_wait;
              nsel_q  <= ~w_hit;
              nrd_q   <= m_nread;
              nwr_q   <= m_nwrite;
              state_q <= ST_ACCESS;
            end
          end
        end

        ST_ACCESS: begin
          if (cnt_q == '0) begin
            if (rd_q) rdata_q <= w_sel_rdata;
            nsel_q  <= '1;
            nrd_q   <= 1'b1;
            nwr_q   <= 1'b1;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        ST_DONE: begin
          // A master still holding its strobe must release before a new request
          state_q <= w_bus_idle ? ST_IDLE : ST_HOLD;
        end

        ST_HOLD: begin
          if (w_bus_idle) state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_rdata  = rdata_q;
  assign m_ready  = ready_q;
  assign err      = err_q;
  assign s_addr   = addr_q;
  assign s_wdata  = wdata_q;
  assign s_nread  = nrd_q;
  assign s_nwrite = nwr_q;
  assign s_nsel   = nsel_q;

endmodule : bus_fabric
`default_nettype wire

// File: tb/tb_bus_fabric.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_fabric
//  Description : Scoreboard testbench for bus_fabric. The driver pushes the
//                expected completion of each request; a monitor tracks slave
//                activity and pops/compares on every m_ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_fabric;

  localparam logic [63:0] C_BASE = {16'hA000, 16'h2000, 16'hC000, 16'h0000};
  localparam logic [63:0] C_MASK = {16'hF000, 16'hF000, 16'hE000, 16'h8000};
  localparam logic [15:0] C_WAIT = {4'd5, 4'd1, 4'd3, 4'd0};
  localparam logic [31:0] C_SDAT = {8'h96, 8'hC3, 8'h5A, 8'h3C};

  logic        clk;
  logic        rst;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_nread;
  logic        m_nwrite;
  logic [7:0]  m_rdata;
  logic        m_ready;
  logic        err;
  logic [15:0] s_addr;
  logic [7:0]  s_wdata;
  logic        s_nread;
  logic        s_nwrite;
  logic [3:0]  s_nsel;
  logic [31:0] s_rdata;

  bus_fabric #(
    .ADDR_W   (16),
    .DATA_W   (8),
    .NSLAVE   (4),
    .BASE     (C_BASE),
    .MASK     (C_MASK),
    .WAIT     (C_WAIT),
    .OPEN_BUS (8'hFF)
  ) dut (
    .clock    (clk),
    .reset    (rst),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_nread  (m_nread),
    .m_nwrite (m_nwrite),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready),
    .err      (err),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_nread  (s_nread),
    .s_nwrite (s_nwrite),
    .s_nsel   (s_nsel),
    .s_rdata  (s_rdata)
  );

  // Slave models: drive their fixed byte only while selected and read-strobed
  always_comb begin
    s_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (!s_nsel[i] && !s_nread) s_rdata[i*8 +: 8] = C_SDAT[i*8 +: 8];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [3:0]  nsel;
    int          acc;
    int          rdn;
    int          wrn;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        chk_rdata;
    logic [7:0]  rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   mon_en  = 1'b0;
  int   acc_cnt = 0;
  int   rd_cnt  = 0;
  int   wr_cnt  = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endfunction

  // Monitor: track slave activity, compare against scoreboard on m_ready
  always @(negedge clk) begin
    if (mon_en) begin
      if (s_nsel != 4'hF) begin
        if (sb.size() == 0) begin
          check("unexpected_select", 32'(s_nsel), 32'hF);
        end else begin
          acc_cnt++;
          if (!s_nread)  rd_cnt++;
          if (!s_nwrite) wr_cnt++;
          check("nsel_pattern", 32'(s_nsel), 32'(sb[0].nsel));
          if (acc_cnt == 1) begin
            check("s_addr", 32'(s_addr), 32'(sb[0].addr));
            if (sb[0].wrn != 0) check("s_wdata", 32'(s_wdata), 32'(sb[0].wdata));
          end
        end
      end
      if (m_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_ready", 32'(m_ready), 32'h0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("ready_cycle", 32'(cyc), 32'(e.cyc));
          check("access_cycles", 32'(acc_cnt), 32'(e.acc));
          check("nread_cycles", 32'(rd_cnt), 32'(e.rdn));
          check("nwrite_cycles", 32'(wr_cnt), 32'(e.wrn));
          check("err", 32'(err), 32'(e.err));
          if (e.chk_rdata) check("m_rdata", 32'(m_rdata), 32'(e.rdata));
        end
        acc_cnt = 0;
        rd_cnt  = 0;
        wr_cnt  = 0;
      end
    end
  end

  // Issue one request; nsel==4'hF means no slave is expected to be touched
  task automatic req(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [7:0] d, input logic [3:0] nsel, input int w,
                     input logic [7:0] rdata, input logic e_err, input int hold);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    e.nsel      = nsel;
    e.acc       = (nsel == 4'hF) ? 0 : w + 1;
    e.rdn       = (nsel != 4'hF && rd) ? w + 1 : 0;
    e.wrn       = (nsel != 4'hF && wr) ? w + 1 : 0;
    e.cyc       = cyc + ((nsel == 4'hF) ? 1 : w + 2);
    e.addr      = a;
    e.wdata     = d;
    e.chk_rdata = rd;
    e.rdata     = rdata;
    e.err       = e_err;
    sb.push_back(e);
    m_addr   = a;
    m_wdata  = d;
    m_nread  = ~rd;
    m_nwrite = ~wr;
    @(posedge clk); #1;
    m_addr  = ~a;
    m_wdata = ~d;
    n = 0;
    while (!m_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_seen", 32'(m_ready), 32'h1);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    m_nread  = 1'b1;
    m_nwrite = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    m_addr   = '0;
    m_wdata  = '0;
    m_nread  = 1'b1;
    m_nwrite = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_m_ready",  32'(m_ready),  32'h0);
    check("rst_err",      32'(err),      32'h0);
    check("rst_m_rdata",  32'(m_rdata),  32'hFF);
    check("rst_s_nsel",   32'(s_nsel),   32'hF);
    check("rst_s_nread",  32'(s_nread),  32'h1);
    check("rst_s_nwrite", 32'(s_nwrite), 32'h1);
    check("rst_s_addr",   32'(s_addr),   32'h0);
    check("rst_s_wdata",  32'(s_wdata),  32'h0);
    mon_en = 1'b1;

    //   rd    wr    addr      wdata  nsel     W  rdata  err  hold
    req(1'b1, 1'b0, 16'h0100, 8'h00, 4'b1110, 0, 8'h3C, 1'b0, 0);
    req(1'b0, 1'b1, 16'hC000, 8'hA5, 4'b1101, 3, 8'h00, 1'b0, 0);
    req(1'b1, 1'b0, 16'h2000, 8'h00, 4'b1110, 0, 8'h3C, 1'b0, 0);
    req(1'b1, 1'b0, 16'hA010, 8'h00, 4'b0111, 5, 8'h96, 1'b0, 0);
    req(1'b1, 1'b0, 16'hFF80, 8'h00, 4'b1111, 0, 8'hFF, 1'b1, 0);
    req(1'b1, 1'b0, 16'h0100, 8'h00, 4'b1110, 0, 8'h3C, 1'b1, 0);
    req(1'b0, 1'b1, 16'hC000, 8'h5A, 4'b1101, 3, 8'h00, 1'b1, 10);
    req(1'b1, 1'b0, 16'hC001, 8'h00, 4'b1101, 3, 8'h5A, 1'b1, 0);

    // Reset in the middle of a WAIT=5 read
    mon_en = 1'b0;
    @(posedge clk); #1;
    m_addr  = 16'hA010;
    m_nread = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_access_sel", 32'(s_nsel), 32'h7);
    rst     = 1'b1;
    m_nread = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_s_nsel",   32'(s_nsel),   32'hF);
    check("abort_s_nread",  32'(s_nread),  32'h1);
    check("abort_m_ready",  32'(m_ready),  32'h0);
    check("abort_err",      32'(err),      32'h0);
    check("abort_m_rdata",  32'(m_rdata),  32'hFF);
    mon_en = 1'b1;

    // Both strobes low: error, no slave touched; then normal operation resumes
    req(1'b1, 1'b1, 16'h0100, 8'hC3, 4'b1111, 0, 8'hFF, 1'b1, 0);
    req(1'b1, 1'b0, 16'hA010, 8'h00, 4'b0111, 5, 8'h96, 1'b1, 0);

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_bus_fabric
`default_nettype wire
